// File: rtl/bus2_pkg.sv
// Shared bus-2 definitions: command encoding, controller states and default geometry.
package bus2_pkg;

    typedef enum logic [1:0] {
        C2_NOP        = 2'd0,
        C2_RESPONSE   = 2'd1,
        C2_READ_LINE  = 2'd2,
        C2_WRITE_LINE = 2'd3
    } c2_cmd_t;

    typedef enum logic [2:0] {
        IDLE,
        WR_RECV,
        WR_WAIT,
        RD_WAIT,
        RD_SEND,
        WR_RESP
    } mem_ctr_state_t;

    localparam int DEF_DATA_W     = 16;
    localparam int DEF_LINE_BYTES = 16;
    localparam int DEF_MEM_BYTES  = 65536;

    // Number of data beats needed to move one cache line.
    function automatic int beats_per_line(input int line_bytes, input int data_w);
        return (line_bytes * 8) / data_w;
    endfunction

endpackage

// File: rtl/mem_ctr_ram.sv
// Beat-wide RAM with byte-lane write enables and an asynchronous beat-wide read port.
// Byte j of a beat lives in bits [8j+7:8j], giving little-endian order inside a word.
module mem_ctr_ram #(
    parameter int DATA_W = 16,
    parameter int WORDS  = 32768,
    parameter int AW     = $clog2(WORDS)
) (
    input  logic                  CLK,
    input  logic                  we,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_W-1:0]     rdata
);

    localparam int BE_W = DATA_W / 8;

    logic [DATA_W-1:0] mem [WORDS];

    // Commit each enabled byte lane of the write beat on the rising edge.
    always_ff @(posedge CLK) begin
        if (we) begin
            for (int j = 0; j < BE_W; j++) begin
                if (be[j]) begin
                    mem[waddr][8*j +: 8] <= wdata[8*j +: 8];
                end
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mem_ctr_line.sv
// Bus-2 line memory controller: accepts whole-line reads and writes from one cache,
// waits a programmable latency, then answers with a response (and data for reads).
// Bus 2 is exposed as separate in/out halves with output enables.
module mem_ctr_line
    import bus2_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int LINE_BYTES = DEF_LINE_BYTES,
    parameter int MEM_BYTES  = DEF_MEM_BYTES,
    parameter int ADDR_W     = 15,
    parameter int DELAY      = 100,
    parameter int CRIT_FIRST = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [1:0]        c2_in,
    input  logic [ADDR_W-1:0] a2_in,
    input  logic [DATA_W-1:0] d2_in,
    output logic [1:0]        c2_out,
    output logic              c2_oe,
    output logic [DATA_W-1:0] d2_out,
    output logic              d2_oe,
    output logic              busy,
    output logic              protocol_err
);

    localparam int BEATS   = beats_per_line(LINE_BYTES, DATA_W);
    localparam int OFF_W   = $clog2(BEATS);
    localparam int BE_W    = DATA_W / 8;
    localparam int LINES   = MEM_BYTES / LINE_BYTES;
    localparam int LINE_W  = $clog2(LINES);
    localparam int WORDS   = LINES * BEATS;
    localparam int WORD_AW = $clog2(WORDS);
    localparam int CNT_W   = $clog2(DELAY + 1);

    localparam logic [OFF_W-1:0] LAST_BEAT  = OFF_W'(BEATS - 1);
    localparam logic [CNT_W-1:0] DELAY_INIT = CNT_W'(DELAY);
    // Counter value seen in cycle DELAY-1 after accept; the counter holds DELAY in cycle 1.
    localparam logic [CNT_W-1:0] LAT_LAST   = CNT_W'(2);

    mem_ctr_state_t state;
    mem_ctr_state_t state_next;

    c2_cmd_t            cmd;
    logic               cmd_is_line_op;
    logic [LINE_W-1:0]  req_line;
    logic [OFF_W-1:0]   req_off;
    logic [OFF_W-1:0]   start_beat;

    logic [LINE_W-1:0]  line_q;
    logic [OFF_W-1:0]   beat_q;
    logic [OFF_W-1:0]   sent_q;
    logic [CNT_W-1:0]   lat_q;
    logic               protocol_err_q;

    logic [OFF_W-1:0]   next_beat;
    logic [CNT_W-1:0]   lat_dec;
    logic               lat_hit;

    logic               ram_we;
    logic [LINE_W-1:0]  wr_line;
    logic [OFF_W-1:0]   wr_beat;
    logic [WORD_AW-1:0] ram_waddr;
    logic [WORD_AW-1:0] ram_raddr;
    logic [DATA_W-1:0]  ram_rdata;

    // The line index is everything above the beat offset, folded onto the RAM size.
    assign cmd            = c2_cmd_t'(c2_in);
    assign cmd_is_line_op = (cmd == C2_READ_LINE) || (cmd == C2_WRITE_LINE);
    assign req_line       = LINE_W'(a2_in >> OFF_W);
    assign req_off        = OFF_W'(int'(a2_in[OFF_W-1:0]) % BEATS);
    assign start_beat     = (CRIT_FIRST != 0) ? req_off : '0;

    assign next_beat = (beat_q == LAST_BEAT) ? '0 : beat_q + OFF_W'(1);
    assign lat_dec   = (lat_q == '0) ? '0 : lat_q - CNT_W'(1);
    assign lat_hit   = (lat_q == LAT_LAST);

    // Beat 0 of a write arrives with the command, before the line register is loaded.
    assign wr_line   = (state == IDLE) ? req_line : line_q;
    assign wr_beat   = (state == IDLE) ? '0 : beat_q;
    assign ram_we    = RESET && (((state == IDLE) && (cmd == C2_WRITE_LINE)) || (state == WR_RECV));
    assign ram_waddr = WORD_AW'(int'(wr_line) * BEATS + int'(wr_beat));
    assign ram_raddr = WORD_AW'(int'(line_q) * BEATS + int'(beat_q));

    mem_ctr_ram #(
        .DATA_W (DATA_W),
        .WORDS  (WORDS),
        .AW     (WORD_AW)
    ) u_ram (
        .CLK   (CLK),
        .we    (ram_we),
        .be    ({BE_W{1'b1}}),
        .waddr (ram_waddr),
        .wdata (d2_in),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: accept in IDLE, count beats and latency elsewhere.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (cmd == C2_READ_LINE) begin
                    state_next = RD_WAIT;
                end else if (cmd == C2_WRITE_LINE) begin
                    state_next = WR_RECV;
                end
            end
            WR_RECV: begin
                if (beat_q == LAST_BEAT) begin
                    state_next = WR_WAIT;
                end
            end
            WR_WAIT: begin
                if (lat_hit) begin
                    state_next = WR_RESP;
                end
            end
            RD_WAIT: begin
                if (lat_hit) begin
                    state_next = RD_SEND;
                end
            end
            RD_SEND: begin
                if (sent_q == LAST_BEAT) begin
                    state_next = IDLE;
                end
            end
            WR_RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Line, beat and latency counters; the latency counter runs from the accept edge on.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            line_q <= '0;
            beat_q <= '0;
            sent_q <= '0;
            lat_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd == C2_READ_LINE) begin
                        line_q <= req_line;
                        beat_q <= start_beat;
                        sent_q <= '0;
                        lat_q  <= DELAY_INIT;
                    end else if (cmd == C2_WRITE_LINE) begin
                        line_q <= req_line;
                        beat_q <= OFF_W'(1);
                        sent_q <= '0;
                        lat_q  <= DELAY_INIT;
                    end
                end
                WR_RECV: begin
                    beat_q <= next_beat;
                    lat_q  <= lat_dec;
                end
                RD_SEND: begin
                    beat_q <= next_beat;
                    sent_q <= sent_q + OFF_W'(1);
                    lat_q  <= lat_dec;
                end
                default: begin
                    lat_q <= lat_dec;
                end
            endcase
        end
    end

    // Registered one-cycle flag for any line command that shows up while busy.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            protocol_err_q <= 1'b0;
        end else begin
            protocol_err_q <= (state != IDLE) && cmd_is_line_op;
        end
    end

    // Bus drive decode: only the respond states own C2, only read data owns D2.
    always_comb begin
        c2_out       = C2_NOP;
        c2_oe        = 1'b0;
        d2_out       = '0;
        d2_oe        = 1'b0;
        busy         = (state != IDLE);
        protocol_err = protocol_err_q;
        case (state)
            RD_SEND: begin
                c2_out = C2_RESPONSE;
                c2_oe  = 1'b1;
                d2_out = ram_rdata;
                d2_oe  = 1'b1;
            end
            WR_RESP: begin
                c2_out = C2_RESPONSE;
                c2_oe  = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_ctr_line.sv
// Self-checking bench for mem_ctr_line: a byte-level memory model feeds a scoreboard of
// expected read beats, and each scenario task checks bus timing cycle by cycle.
module tb_mem_ctr_line;
    import bus2_pkg::*;

    localparam int DATA_W     = 16;
    localparam int LINE_BYTES = 16;
    localparam int MEM_BYTES  = 1024;
    localparam int ADDR_W     = 15;
    localparam int DELAY      = 12;
    localparam int CRIT_FIRST = 1;
    localparam int BEATS      = 8;
    localparam int OFF_W      = 3;
    localparam int LINES      = 64;
    localparam int BPB        = 2;

    logic              CLK = 1'b0;
    logic              RESET;
    logic [1:0]        c2_in;
    logic [ADDR_W-1:0] a2_in;
    logic [DATA_W-1:0] d2_in;
    logic [1:0]        c2_out;
    logic              c2_oe;
    logic [DATA_W-1:0] d2_out;
    logic              d2_oe;
    logic              busy;
    logic              protocol_err;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [DATA_W-1:0] exp_q [$];
    logic [DATA_W-1:0] mon_exp;
    logic [7:0]        model_mem [MEM_BYTES];

    mem_ctr_line #(
        .DATA_W     (DATA_W),
        .LINE_BYTES (LINE_BYTES),
        .MEM_BYTES  (MEM_BYTES),
        .ADDR_W     (ADDR_W),
        .DELAY      (DELAY),
        .CRIT_FIRST (CRIT_FIRST)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .c2_in        (c2_in),
        .a2_in        (a2_in),
        .d2_in        (d2_in),
        .c2_out       (c2_out),
        .c2_oe        (c2_oe),
        .d2_out       (d2_out),
        .d2_oe        (d2_oe),
        .busy         (busy),
        .protocol_err (protocol_err)
    );

    // Free-running 10 ns clock.
    always #5 CLK = ~CLK;

    // Scoreboard: every driven read beat is popped and compared against the model.
    always @(negedge CLK) begin
        if (d2_oe === 1'b1) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("[TB] FAIL d2_beat got=%h want=none", d2_out);
            end else begin
                mon_exp = exp_q.pop_front();
                if (d2_out !== mon_exp) begin
                    tests_failed++;
                    $display("[TB] FAIL d2_beat got=%h want=%h", d2_out, mon_exp);
                end
            end
        end
    end

    // Hard stop in case the scenario sequence ever stalls.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int line_of(input logic [ADDR_W-1:0] a2);
        return (int'(a2) >> OFF_W) % LINES;
    endfunction

    // Expected {c2_oe, c2_out, d2_oe, busy, protocol_err} t cycles after a read command.
    function automatic logic [5:0] rd_model(input int t);
        if (t >= DELAY && t < DELAY + BEATS) return 6'b101110;
        if (t >= 1 && t < DELAY) return 6'b000010;
        return 6'b000000;
    endfunction

    // Same vector for a write command.
    function automatic logic [5:0] wr_model(input int t);
        if (t == DELAY) return 6'b101010;
        if (t >= 1 && t < DELAY) return 6'b000010;
        return 6'b000000;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic model_write(input logic [ADDR_W-1:0] a2, input int k, input logic [DATA_W-1:0] beat);
        int ln;
        ln = line_of(a2);
        for (int j = 0; j < BPB; j++) begin
            model_mem[ln*LINE_BYTES + k*BPB + j] = beat[8*j +: 8];
        end
    endtask

    task automatic push_read(input logic [ADDR_W-1:0] a2, input int count);
        int ln;
        int s;
        int b;
        logic [DATA_W-1:0] v;
        ln = line_of(a2);
        s  = CRIT_FIRST ? (int'(a2) % BEATS) : 0;
        for (int k = 0; k < count; k++) begin
            b = (s + k) % BEATS;
            for (int j = 0; j < BPB; j++) begin
                v[8*j +: 8] = model_mem[ln*LINE_BYTES + b*BPB + j];
            end
            exp_q.push_back(v);
        end
    endtask

    // Stimulus only: write a full line (beat k = base + k*step) and wait until idle again.
    task automatic do_write(input logic [ADDR_W-1:0] a2, input logic [DATA_W-1:0] base,
                            input logic [DATA_W-1:0] step);
        for (int k = 0; k < BEATS; k++) begin
            c2_in = (k == 0) ? C2_WRITE_LINE : C2_NOP;
            a2_in = a2;
            d2_in = DATA_W'(base + DATA_W'(k) * step);
            model_write(a2, k, d2_in);
            tick();
        end
        c2_in = C2_NOP;
        repeat (DELAY + 2 - BEATS) tick();
    endtask

    task automatic test_reset();
        logic [5:0] obs;
        RESET = 1'b0;
        c2_in = C2_READ_LINE;
        a2_in = '0;
        d2_in = '0;
        repeat (3) tick();
        @(negedge CLK);
        obs = {c2_oe, c2_out, d2_oe, busy, protocol_err};
        tests_run++;
        if (obs !== 6'b000000) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs got=%b want=%b", obs, 6'b000000);
        end
        tests_run++;
        if (d2_out !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_d2_out got=%h want=0000", d2_out);
        end
        tick();
        RESET = 1'b1;
        c2_in = C2_NOP;
        tick();
    endtask

    task automatic test_read_basic();
        logic [5:0] obs;
        logic [5:0] want;
        do_write(ADDR_W'(5 << OFF_W), 16'h0100, 16'h0202);
        for (int t = 0; t <= DELAY + BEATS + 1; t++) begin
            c2_in = (t == 0) ? C2_READ_LINE : C2_NOP;
            a2_in = ADDR_W'(5 << OFF_W);
            if (t == 0) push_read(a2_in, BEATS);
            @(negedge CLK);
            obs  = {c2_oe, c2_out, d2_oe, busy, protocol_err};
            want = rd_model(t);
            tests_run++;
            if (obs !== want) begin
                tests_failed++;
                $display("[TB] FAIL read_basic_c%0d got=%b want=%b", t, obs, want);
            end
            tick();
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL read_basic_leftover got=%0d want=0", exp_q.size());
        end
    endtask

    task automatic test_crit_first();
        logic [5:0] obs;
        logic [5:0] want;
        for (int t = 0; t <= DELAY + BEATS + 1; t++) begin
            c2_in = (t == 0) ? C2_READ_LINE : C2_NOP;
            a2_in = ADDR_W'((5 << OFF_W) | 6);
            if (t == 0) push_read(a2_in, BEATS);
            @(negedge CLK);
            obs  = {c2_oe, c2_out, d2_oe, busy, protocol_err};
            want = rd_model(t);
            tests_run++;
            if (obs !== want) begin
                tests_failed++;
                $display("[TB] FAIL crit_first_c%0d got=%b want=%b", t, obs, want);
            end
            tick();
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL crit_first_leftover got=%0d want=0", exp_q.size());
        end
    endtask

    task automatic test_write_then_read();
        logic [5:0] obs;
        logic [5:0] want;
        for (int t = 0; t <= DELAY + 2; t++) begin
            c2_in = (t == 0) ? C2_WRITE_LINE : C2_NOP;
            a2_in = ADDR_W'((3 << OFF_W) | 5);
            if (t < BEATS) begin
                d2_in = DATA_W'(16'hA000 + t);
                model_write(a2_in, t, d2_in);
            end else begin
                d2_in = '0;
            end
            @(negedge CLK);
            obs  = {c2_oe, c2_out, d2_oe, busy, protocol_err};
            want = wr_model(t);
            tests_run++;
            if (obs !== want) begin
                tests_failed++;
                $display("[TB] FAIL write_c%0d got=%b want=%b", t, obs, want);
            end
            tick();
        end
        for (int t = 0; t <= DELAY + BEATS + 1; t++) begin
            c2_in = (t == 0) ? C2_READ_LINE : C2_NOP;
            a2_in = ADDR_W'(3 << OFF_W);
            if (t == 0) push_read(a2_in, BEATS);
            @(negedge CLK);
            obs  = {c2_oe, c2_out, d2_oe, busy, protocol_err};
            want = rd_model(t);
            tests_run++;
            if (obs !== want) begin
                tests_failed++;
                $display("[TB] FAIL raw_read_c%0d got=%b want=%b", t, obs, want);
            end
            tick();
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL raw_read_leftover got=%0d want=0", exp_q.size());
        end
    endtask

    task automatic test_collision();
        logic [5:0] obs;
        logic [5:0] want;
        for (int t = 0; t <= DELAY + BEATS + 1; t++) begin
            c2_in = (t == 0 || t == 3) ? C2_READ_LINE : C2_NOP;
            a2_in = (t == 0) ? ADDR_W'((5 << OFF_W) | 2) : ADDR_W'(3 << OFF_W);
            if (t == 0) push_read(a2_in, BEATS);
            @(negedge CLK);
            obs  = {c2_oe, c2_out, d2_oe, busy, protocol_err};
            want = rd_model(t) | ((t == 4) ? 6'b000001 : 6'b000000);
            tests_run++;
            if (obs !== want) begin
                tests_failed++;
                $display("[TB] FAIL collision_c%0d got=%b want=%b", t, obs, want);
            end
            tick();
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL collision_leftover got=%0d want=0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] obs;
        logic [5:0] want;
        for (int t = 0; t <= 20 + DELAY + BEATS + 1; t++) begin
            c2_in = (t == 0 || t == 20) ? C2_READ_LINE : C2_NOP;
            a2_in = (t < 20) ? ADDR_W'(3 << OFF_W) : ADDR_W'((5 << OFF_W) | 7);
            if (t == 0 || t == 20) push_read(a2_in, BEATS);
            @(negedge CLK);
            obs  = {c2_oe, c2_out, d2_oe, busy, protocol_err};
            want = (t < 20) ? rd_model(t) : rd_model(t - 20);
            tests_run++;
            if (obs !== want) begin
                tests_failed++;
                $display("[TB] FAIL back_to_back_c%0d got=%b want=%b", t, obs, want);
            end
            tick();
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL back_to_back_leftover got=%0d want=0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid_read();
        logic [5:0] obs;
        logic [5:0] want;
        for (int t = 0; t <= 16 + DELAY + BEATS + 1; t++) begin
            RESET = (t == 14) ? 1'b0 : 1'b1;
            c2_in = (t == 0 || t == 16) ? C2_READ_LINE : C2_NOP;
            a2_in = (t < 16) ? ADDR_W'(3 << OFF_W) : ADDR_W'(5 << OFF_W);
            if (t == 0) push_read(a2_in, 3);
            if (t == 16) push_read(a2_in, BEATS);
            @(negedge CLK);
            obs = {c2_oe, c2_out, d2_oe, busy, protocol_err};
            if (t <= 14) want = rd_model(t);
            else if (t == 15) want = 6'b000000;
            else want = rd_model(t - 16);
            tests_run++;
            if (obs !== want) begin
                tests_failed++;
                $display("[TB] FAIL reset_mid_c%0d got=%b want=%b", t, obs, want);
            end
            if (t == 15) begin
                tests_run++;
                if (d2_out !== '0) begin
                    tests_failed++;
                    $display("[TB] FAIL reset_mid_d2_out got=%h want=0000", d2_out);
                end
            end
            tick();
        end
        RESET = 1'b1;
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_leftover got=%0d want=0", exp_q.size());
        end
    endtask

    task automatic test_line_wrap();
        logic [5:0] obs;
        logic [5:0] want;
        do_write(ADDR_W'(((LINES + 7) << OFF_W) | 5), 16'h5A00, 16'h0111);
        for (int t = 0; t <= DELAY + BEATS + 1; t++) begin
            c2_in = (t == 0) ? C2_READ_LINE : C2_NOP;
            a2_in = ADDR_W'(((2 * LINES + 7) << OFF_W) | 3);
            if (t == 0) push_read(a2_in, BEATS);
            @(negedge CLK);
            obs  = {c2_oe, c2_out, d2_oe, busy, protocol_err};
            want = rd_model(t);
            tests_run++;
            if (obs !== want) begin
                tests_failed++;
                $display("[TB] FAIL line_wrap_c%0d got=%b want=%b", t, obs, want);
            end
            tick();
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL line_wrap_leftover got=%0d want=0", exp_q.size());
        end
    endtask

    // Scenario sequence; every task starts and ends just after a rising edge with the DUT idle.
    initial begin
        RESET = 1'b0;
        c2_in = C2_NOP;
        a2_in = '0;
        d2_in = '0;
        test_reset();
        test_read_basic();
        test_crit_first();
        test_write_then_read();
        test_collision();
        test_back_to_back();
        test_reset_mid_read();
        test_line_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
